hamming_enc_ctrl: RTL and testbench
===================================

# hamming_enc_ctrl

Sequencing controller for the protected Hamming encode path. It authenticates a serial security code, buffers the 4-bit user word, and pulses the datapath register's load. It then captures the 7-bit Hamming codeword and presents it on a valid/ready output. It sits between the user-side stimulus and the `register`/`hamming` pair, and replaces the ad-hoc handshake around `fsm_top`.

## Interface
- `CODE_LEN`, 4: number of security-code bits, 1..8.
- `CODE`, 4'b1011: expected code, `CODE_LEN` bits wide, received MSB first.
- `MAX_FAILS`, 3: consecutive failed attempts before lockout, ≥1.
- `LOCK_CYCLES`, 16: lockout duration in clocks, ≥1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin transaction; sampled only in IDLE.
- `data_in`  in  4  user word, captured with `start`.
- `code_bit`  in  1  serial code bit.
- `code_valid`  in  1  `code_bit` qualifier; honoured only in COLLECT.
- `hamming_out`  in  7  codeword from the `hamming` instance.
- `reg_data`  out  4  buffered word, drives `register.in`.
- `load`  out  1  one-cycle load strobe to `register`.
- `enc_data`  out  7  captured codeword.
- `enc_valid`  out  1  `enc_data` valid.
- `enc_ready`  in  1  downstream accepts.
- `busy`  out  1  high in every state except IDLE.
- `auth_fail`  out  1  one-cycle pulse on a code mismatch.
- `locked`  out  1  high in LOCKED.

## Operation
- States: IDLE, COLLECT, CHECK, LOAD, CAPTURE, OUT, LOCKED.
- **IDLE**
  - With `start`=1: `data_q` ← `data_in`, `bit_cnt` ← 0, `shift` ← 0, next state COLLECT.
- **COLLECT**
  - Each cycle with `code_valid`=1: `shift` ← {`shift`[CODE_LEN-2:0], `code_bit`}.
  - When that accepted bit is number `CODE_LEN`, next state is CHECK.
  - Cycles with `code_valid`=0 hold state. There is no timeout.
- **CHECK** (one cycle)
  - `shift`==`CODE`: next state LOAD.
  - Otherwise: `auth_fail`=1 and `fail_cnt`+1.
    - If `fail_cnt`+1 == `MAX_FAILS`: next state LOCKED.
    - Else: next state IDLE.
- **LOAD**
  - `load`=1 for exactly this cycle. Next state CAPTURE.
- **CAPTURE**
  - `enc_data` ← `hamming_out`, `enc_valid` ← 1, next state OUT.
- **OUT**
  - `enc_valid` held high and `enc_data` held stable until `enc_ready`=1.
  - On the handshake edge: `enc_valid` ← 0, `fail_cnt` ← 0, next state IDLE.
- **LOCKED**
  - `lock_cnt` counts `LOCK_CYCLES` clocks.
  - At expiry: `fail_cnt` ← 0, next state IDLE.
  - `start` is ignored.
- `reg_data` = `data_q` continuously.
- `enc_data` keeps its last value after the handshake.
- `start` outside IDLE is ignored; it is not queued.
- `code_valid` outside COLLECT is ignored.
- `fail_cnt` saturates at `MAX_FAILS`.
- `fail_cnt` resets only on a successful handshake, on lockout expiry, or on `rst`.

## Timing
- Reset values: all outputs 0, state IDLE, `data_q`, `shift`, `fail_cnt` and `lock_cnt` all 0.
- Reset asserted mid-operation aborts immediately. A pending `enc_valid` is dropped.
- Pipeline, with E0 = the edge accepting the last code bit:
  - E0+1: state LOAD, `load` high.
  - E0+2: `register` updates, state CAPTURE.
  - E0+3: `enc_valid` rises.
- The earliest next `start` is accepted on the cycle after the handshake edge.
- `enc_ready` may be high before `enc_valid`. The handshake then completes on the first OUT cycle.
- `auth_fail` is high in the CHECK cycle only.
- `locked` is high for exactly `LOCK_CYCLES` cycles.

## Configuration
- Macro: `HAMMING_ENC_CTRL_LOCKOUT_EN`.
- **Defined:** `fail_cnt`, LOCKED and `lock_cnt` behave as specified above.
- **Undefined:**
  - LOCKED, `fail_cnt` and `lock_cnt` are not synthesised.
  - `locked` is tied to 0.
  - A mismatch always returns to IDLE, with the `auth_fail` pulse unchanged.

## Test plan
- **Correct code:** reset; `start` with `data_in`=4'b1011; code 1,0,1,1 on consecutive cycles; bench drives `hamming_out`=7'h55.
  - Required: `load` pulses once at E0+1, and `reg_data`=4'b1011 during it.
  - Required: `enc_valid` at E0+3 with `enc_data`=7'h55.
- **Backpressure:** as in the correct-code case, with `enc_ready` held 0 for 5 cycles.
  - Required: `enc_valid` and `enc_data` stay stable while stalled.
  - Required: `enc_valid` clears 1 cycle after `enc_ready`=1.
- **Gapped code bits:** `code_valid` low for 3 cycles between bits 2 and 3.
  - Required: the code is still accepted, and `enc_valid` arrives 3 cycles after the last bit.
- **Lockout:** three attempts with code 0000.
  - Required: three `auth_fail` pulses.
  - Required: `locked`=1 for 16 cycles, with `start` ignored.
  - Required: a following correct attempt succeeds.
- **Reset mid-COLLECT:** assert `rst`=0 after 2 code bits.
  - Required: all outputs are 0 and `busy`=0.
  - Required: a full correct sequence then succeeds.
- **Macro undefined:** five wrong attempts.
  - Required: five `auth_fail` pulses and `locked` is never 1.

Source files
------------

// File: rtl/hamming_enc_ctrl.sv
// hamming_enc_ctrl: sequencing controller for the protected Hamming encode path.
// Authenticates a serial security code, buffers the 4-bit user word, strobes the
// datapath register load, captures the 7-bit codeword and presents it on a
// valid/ready output.
//
// Configuration macro: HAMMING_ENC_CTRL_LOCKOUT_EN
//   defined   - consecutive failures are counted and MAX_FAILS of them lock the
//               block out for LOCK_CYCLES clocks.
//   undefined - no failure counter or lockout; locked is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        begin transaction (sampled in IDLE only)
//   data_in      user word, captured with start
//   code_bit     serial security-code bit, MSB first
//   code_valid   code_bit qualifier (honoured in COLLECT only)
//   hamming_out  codeword from the hamming instance
//   reg_data     buffered word to register.in
//   load         one-cycle load strobe to register
//   enc_data     captured codeword
//   enc_valid    enc_data valid
//   enc_ready    downstream accepts enc_data
//   busy         high in every state except IDLE
//   auth_fail    one-cycle pulse on a code mismatch
//   locked       high while locked out
module hamming_enc_ctrl #(
  parameter int unsigned          CODE_LEN    = 4,
  parameter logic [CODE_LEN-1:0]  CODE        = CODE_LEN'(4'b1011),
  parameter int unsigned          MAX_FAILS   = 3,
  parameter int unsigned          LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data_in,
  input  logic       code_bit,
  input  logic       code_valid,
  input  logic [6:0] hamming_out,
  output logic [3:0] reg_data,
  output logic       load,
  output logic [6:0] enc_data,
  output logic       enc_valid,
  input  logic       enc_ready,
  output logic       busy,
  output logic       auth_fail,
  output logic       locked
);

  localparam int unsigned BW = $clog2(CODE_LEN + 1);

  // Elaboration-time parameter range guard.
  if (CODE_LEN < 1 || CODE_LEN > 8 || MAX_FAILS < 1 || LOCK_CYCLES < 1) begin : g_bad_cfg
    $error("hamming_enc_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_LOAD    = 3'd3,
    S_CAPTURE = 3'd4,
    S_OUT     = 3'd5,
    S_LOCKED  = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          data_q, data_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [6:0]          enc_data_q, enc_data_d;
  logic                enc_valid_q, enc_valid_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;
  logic                auth_fail_q, auth_fail_d;

`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
`endif

  // Next-state and next-output logic; outputs are decoded from the next state
  // so every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    enc_data_d  = enc_data_q;
    enc_valid_d = enc_valid_q;
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
    fail_cnt_d  = fail_cnt_q;
    lock_cnt_d  = lock_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d    = data_in;
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (code_valid) begin
          shift_d   = CODE_LEN'({shift_q, code_bit});
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(CODE_LEN - 1)) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (shift_q == CODE) begin
          state_d = S_LOAD;
        end else begin
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
          if (fail_cnt_q != FW'(MAX_FAILS)) fail_cnt_d = fail_cnt_q + FW'(1);
          if (FW'(fail_cnt_q + FW'(1)) == FW'(MAX_FAILS)) begin
            lock_cnt_d = '0;
            state_d    = S_LOCKED;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_LOAD: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        enc_data_d  = hamming_out;
        enc_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (enc_ready) begin
          enc_valid_d = 1'b0;
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
          fail_cnt_d  = '0;
`endif
          state_d     = S_IDLE;
        end
      end
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
      S_LOCKED: begin
        // lock_cnt is 0 on the first LOCKED cycle, so this gives LOCK_CYCLES cycles.
        if (lock_cnt_q == LW'(LOCK_CYCLES - 1)) begin
          lock_cnt_d = '0;
          fail_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    load_d      = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
    // The mismatch verdict is taken on the final shifted value as CHECK is entered.
    auth_fail_d = (state_d == S_CHECK) && (shift_d != CODE);
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
    locked_d    = (state_d == S_LOCKED);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      enc_data_q  <= '0;
      enc_valid_q <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      auth_fail_q <= 1'b0;
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
      fail_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      enc_data_q  <= enc_data_d;
      enc_valid_q <= enc_valid_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      auth_fail_q <= auth_fail_d;
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
      fail_cnt_q  <= fail_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
`endif
    end
  end

  assign reg_data  = data_q;
  assign load      = load_q;
  assign enc_data  = enc_data_q;
  assign enc_valid = enc_valid_q;
  assign busy      = busy_q;
  assign auth_fail = auth_fail_q;
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
  assign locked    = locked_q;
`else
  assign locked    = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_enc_ctrl.sv
// Bench for hamming_enc_ctrl: a timestamp-based transaction model predicts every
// output each cycle; directed scenarios pin key timings with literal values and
// a randomized phase exercises gaps, backpressure and wrong codes.
`timescale 1ns/1ps
module tb_hamming_enc_ctrl;
  localparam int unsigned         CODE_LEN    = 4;
  localparam logic [CODE_LEN-1:0] CODE        = 4'b1011;
  localparam int unsigned         MAX_FAILS   = 3;
  localparam int unsigned         LOCK_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic       code_bit = 1'b0;
  logic       code_valid = 1'b0;
  logic [6:0] hamming_out = 7'h0;
  logic       enc_ready = 1'b0;
  logic [3:0] reg_data;
  logic       load;
  logic [6:0] enc_data;
  logic       enc_valid;
  logic       busy;
  logic       auth_fail;
  logic       locked;

  hamming_enc_ctrl #(
    .CODE_LEN(CODE_LEN), .CODE(CODE), .MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .code_bit(code_bit),
    .code_valid(code_valid), .hamming_out(hamming_out), .reg_data(reg_data),
    .load(load), .enc_data(enc_data), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .busy(busy), .auth_fail(auth_fail), .locked(locked)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errs  = 0;
  int n     = 0;
  int af_pulses = 0, lk_cycles = 0, load_pulses = 0;
  bit ham_rand = 1'b0;

  // Model: a transaction is described by when it started, when its last code bit
  // landed (t0), whether that code matched, and when any lockout ends.
  bit         m_collect = 1'b0;
  int         m_nbits = 0;
  int         m_acc = 0;
  logic [3:0] m_word = 4'h0;
  int         m_t0 = -100;
  bit         m_ok = 1'b0;
  bit         m_out = 1'b0;
  int         m_lock_end = -100;
  logic [6:0] m_enc = 7'h0;
  bit         m_valid = 1'b0;
  bit         e_busy = 1'b0, e_load = 1'b0, e_af = 1'b0, e_locked = 1'b0;
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
  int         m_fails = 0;
`endif

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, n, act, exp);
    end
  endfunction

  function automatic void timeout(input string nm);
    tests++;
    errs++;
    $display("FAIL %s timeout at cycle %0d", nm, n);
  endfunction

  function automatic void model_reset();
    m_collect = 1'b0; m_nbits = 0; m_acc = 0; m_word = 4'h0;
    m_t0 = -100; m_ok = 1'b0; m_out = 1'b0; m_lock_end = -100;
    m_enc = 7'h0; m_valid = 1'b0;
    e_busy = 1'b0; e_load = 1'b0; e_af = 1'b0; e_locked = 1'b0;
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
    m_fails = 0;
`endif
  endfunction

  // Advance the model across clock edge n, using the inputs sampled at that edge.
  function automatic void model_step();
    bit was_idle    = !e_busy;
    bit was_collect = m_collect;
    bit was_out     = m_out;
    if (was_idle && start) begin
      m_collect = 1'b1; m_nbits = 0; m_acc = 0; m_word = data_in;
    end else if (was_collect && code_valid) begin
      m_acc = (m_acc * 2 + int'(code_bit)) % (1 << CODE_LEN);
      m_nbits++;
      if (m_nbits == int'(CODE_LEN)) begin
        m_collect = 1'b0;
        m_t0 = n;
        m_ok = (m_acc == int'(CODE));
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
        if (!m_ok) begin
          m_fails++;
          if (m_fails == int'(MAX_FAILS)) m_lock_end = n + int'(LOCK_CYCLES);
        end
`endif
      end
    end
    if (m_ok && n == m_t0 + 3) begin
      m_enc = hamming_out; m_valid = 1'b1; m_out = 1'b1;
    end else if (was_out && enc_ready) begin
      m_valid = 1'b0; m_out = 1'b0;
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
      m_fails = 0;
`endif
    end
`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
    if (n == m_lock_end + 1) m_fails = 0;
`endif
    e_load   = m_ok && (n == m_t0 + 1);
    e_af     = !m_ok && (n == m_t0);
    e_locked = (n > m_lock_end - int'(LOCK_CYCLES)) && (n <= m_lock_end);
    e_busy   = m_collect || (n == m_t0) || (m_ok && n > m_t0 && n <= m_t0 + 2) ||
               m_out || e_locked;
  endfunction

  // Compare process: every cycle, all outputs against the model.
  initial begin
    forever begin
      @(posedge clk);
      n++;
      if (!rst) model_reset();
      else      model_step();
      #1;
      chk("busy",      32'(busy),      32'(e_busy));
      chk("load",      32'(load),      32'(e_load));
      chk("auth_fail", 32'(auth_fail), 32'(e_af));
      chk("locked",    32'(locked),    32'(e_locked));
      chk("enc_valid", 32'(enc_valid), 32'(m_valid));
      chk("enc_data",  32'(enc_data),  32'(m_enc));
      chk("reg_data",  32'(reg_data),  32'(m_word));
      if (auth_fail === 1'b1) af_pulses++;
      if (locked === 1'b1)    lk_cycles++;
      if (load === 1'b1)      load_pulses++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ham_rand) hamming_out = 7'($urandom);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", n);
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int k = 0;
    while (e_busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (e_busy) timeout("wait_idle");
  endtask

  task automatic send_bits(input logic [CODE_LEN-1:0] code, input int gap_pos,
                           input int gap_len, input bit noisy_start);
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      if (i == gap_pos) begin
        for (int g = 0; g < gap_len; g++) begin
          code_valid = 1'b0;
          code_bit   = 1'($urandom);
          start      = noisy_start ? 1'($urandom) : 1'b0;
          @(negedge clk);
        end
      end
      code_valid = 1'b1;
      code_bit   = code[CODE_LEN-1-i];
      start      = noisy_start ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    code_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic run_txn(input logic [3:0] word, input logic [CODE_LEN-1:0] code,
                         input int gap_pos, input int gap_len, input int stall, input bit early);
    int k;
    wait_idle();
    start = 1'b1; data_in = word;
    code_valid = 1'($urandom); code_bit = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    send_bits(code, gap_pos, gap_len, 1'b1);
    enc_ready = early;
    if (code == CODE) begin
      k = 0;
      while (!m_out && k < 20) begin @(negedge clk); k++; end
      if (!m_out) timeout("enc_valid_rise");
      if (!early) repeat (stall) @(negedge clk);
      enc_ready = 1'b1;
      k = 0;
      while (m_out && k < 20) begin @(negedge clk); k++; end
      if (m_out) timeout("handshake");
      enc_ready = 1'b0;
    end
  endtask

  initial begin
    int af0, lk0, ld0;
    logic [CODE_LEN-1:0] wrong;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enc_valid", 32'(enc_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Correct code with 5-cycle backpressure, literal timing pins.
    hamming_out = 7'h55;
    enc_ready = 1'b0;
    start = 1'b1; data_in = 4'b1011;
    @(negedge clk);
    start = 1'b0;
    send_bits(CODE, -1, 0, 1'b0);
    @(posedge clk); #1;
    chk("t1_load_e1", 32'(load), 32'd1);
    chk("t1_reg_data", 32'(reg_data), 32'hB);
    @(posedge clk); #1;
    chk("t1_load_e2", 32'(load), 32'd0);
    chk("t1_valid_e2", 32'(enc_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_e3", 32'(enc_valid), 32'd1);
    chk("t1_data_e3", 32'(enc_data), 32'h55);
    repeat (5) begin
      @(posedge clk); #1;
      chk("t1_stall_valid", 32'(enc_valid), 32'd1);
      chk("t1_stall_data", 32'(enc_data), 32'h55);
    end
    @(negedge clk);
    enc_ready = 1'b1;
    @(posedge clk); #1;
    chk("t1_valid_clear", 32'(enc_valid), 32'd0);
    chk("t1_data_kept", 32'(enc_data), 32'h55);
    @(negedge clk);
    enc_ready = 1'b0;

    // Gapped code bits: 3 idle cycles between bits 2 and 3.
    wait_idle();
    start = 1'b1; data_in = 4'h6;
    @(negedge clk);
    start = 1'b0;
    enc_ready = 1'b1;
    send_bits(CODE, 2, 3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t2_valid_e2", 32'(enc_valid), 32'd0);
    @(posedge clk); #1;
    chk("t2_valid_e3", 32'(enc_valid), 32'd1);
    chk("t2_reg_data", 32'(reg_data), 32'h6);
    @(negedge clk);
    wait_idle();
    enc_ready = 1'b0;

`ifdef HAMMING_ENC_CTRL_LOCKOUT_EN
    // Lockout: three wrong attempts, start ignored while locked, then success.
    af0 = af_pulses; lk0 = lk_cycles;
    run_txn(4'h3, 4'b0000, -1, 0, 0, 1'b0);
    run_txn(4'h3, 4'b0000, -1, 0, 0, 1'b0);
    run_txn(4'h3, 4'b0000, -1, 0, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      start = (i >= 2); data_in = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    chk("lock_af_pulses", 32'(af_pulses - af0), 32'd3);
    chk("lock_cycles", 32'(lk_cycles - lk0), 32'd16);
    ld0 = load_pulses;
    run_txn(4'h9, CODE, -1, 0, 1, 1'b0);
    chk("lock_then_ok", 32'(load_pulses - ld0), 32'd1);
`else
    // Without lockout: five wrong attempts never lock.
    af0 = af_pulses; lk0 = lk_cycles;
    for (int i = 0; i < 5; i++) run_txn(4'h3, 4'b0000, -1, 0, 0, 1'b0);
    wait_idle();
    chk("nolock_af_pulses", 32'(af_pulses - af0), 32'd5);
    chk("nolock_locked", 32'(lk_cycles - lk0), 32'd0);
`endif

    // Reset mid-COLLECT.
    wait_idle();
    start = 1'b1; data_in = 4'hE;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      code_valid = 1'b1; code_bit = CODE[CODE_LEN-1-i];
      @(negedge clk);
    end
    code_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_reg_data", 32'(reg_data), 32'd0);
    chk("mid_rst_outs", 32'({load, enc_valid, auth_fail, locked, enc_data}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ld0 = load_pulses;
    run_txn(4'h5, CODE, -1, 0, 0, 1'b1);
    chk("post_rst_ok", 32'(load_pulses - ld0), 32'd1);

    // Randomized transactions.
    ham_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      wrong = CODE_LEN'($urandom);
      run_txn(4'($urandom), ($urandom_range(0, 9) < 6) ? CODE : wrong,
              int'($urandom_range(0, CODE_LEN)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), 1'($urandom));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
